// File: rtl/nios_pio_pkg.sv
// Shared constants for the debounced PIO input block: register map,
// edge-type encoding and the post-reset settle length.
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam logic [1:0] SETTLE_CYCLES = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

  // True when a transition from_v -> to_v is one the configured edge type captures.
  function automatic logic edge_hit(input edge_type_e kind, input logic from_v, input logic to_v);
    logic hit;
    case (kind)
      EDGE_RISING:  hit = ~from_v & to_v;
      EDGE_FALLING: hit = from_v & ~to_v;
      EDGE_ANY:     hit = from_v ^ to_v;
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/nios_pio_debounce.sv
// One input bit: 2-flop synchronizer, consecutive-cycle debounce counter and
// edge detector. The edge pulse is valid in the cycle the debounced value flips.
module nios_pio_debounce
  import nios_pio_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter edge_type_e EDGE_TYPE       = EDGE_RISING
) (
  input  logic clk,
  input  logic reset,
  input  logic settle_i,
  input  logic in_i,
  output logic deb_o,
  output logic edge_o
);

  localparam logic [15:0] LAST_CNT = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q;
  logic        sync2_q;
  logic        deb_q;
  logic        deb_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Synchronizer stages, debounced value and stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  // During settle the debounced value tracks the synchronizer with no edge reported.
  always_comb begin
    deb_d  = deb_q;
    cnt_d  = 16'd0;
    edge_o = 1'b0;
    if (settle_i) begin
      deb_d = sync2_q;
    end else if (sync2_q != deb_q) begin
      if (cnt_q == LAST_CNT) begin
        deb_d  = sync2_q;
        edge_o = edge_hit(EDGE_TYPE, deb_q, sync2_q);
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      cnt_d = 16'd0;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/nios_pio_inputs.sv
// Avalon-MM PIO input port with per-bit debouncing, edge capture and a
// masked level interrupt.
module nios_pio_inputs
  import nios_pio_pkg::*;
#(
  parameter int         WIDTH           = 8,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter edge_type_e EDGE_TYPE       = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [1:0]       settle_q;
  logic [1:0]       settle_d;
  logic             settle_s;
  logic [WIDTH-1:0] deb_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic [WIDTH-1:0] clr_s;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             irq_q;
  logic             irq_d;
  logic             wr_s;
  logic             unused_s;

  assign unused_s = ^writedata;
  assign wr_s     = chipselect & ~write_n;
  assign settle_s = (settle_q != SETTLE_CYCLES);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .settle_i(settle_s),
      .in_i    (in_port[i]),
      .deb_o   (deb_s[i]),
      .edge_o  (edge_s[i])
    );
  end

  // Settle counter, registers, read data and interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q   <= 2'd0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      settle_q   <= settle_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  // A new edge wins over a write-1-to-clear of the same bit.
  always_comb begin
    settle_d   = settle_q;
    mask_d     = mask_q;
    clr_s      = '0;
    readdata_d = 32'd0;
    if (settle_s) begin
      settle_d = settle_q + 2'd1;
    end else begin
      settle_d = settle_q;
    end
    if (wr_s && (address == ADDR_IRQMASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_s && (address == ADDR_EDGECAP)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    cap_d = (cap_q & ~clr_s) | edge_s;
    irq_d = |(cap_q & mask_q);
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = deb_s;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = cap_q;
      default:      readdata_d = 32'd0;
    endcase
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: doc/nios_pio_inputs.md
NIOS_PIO_INPUTS -- requirements
Module: nios_pio_inputs

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of input bits (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a change (1..65535).
REQ-003 SHALL have parameter EDGE_TYPE, default RISING: capture RISING, FALLING or ANY edge of the debounced input.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port address, input, 2: Avalon-MM register select.
REQ-007 SHALL have port chipselect, input, 1: slave select.
REQ-008 SHALL have port write_n, input, 1: active-low write strobe.
REQ-009 SHALL have port writedata, input, 32: write data.
REQ-010 SHALL have port readdata, output, 32: registered read data.
REQ-011 SHALL have port in_port, input, WIDTH: asynchronous external inputs (buttons, limit switches).
REQ-012 SHALL have port irq, output, 1: level interrupt to the CPU.

Function
REQ-013 SHALL pass each in_port bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL keep a per-bit debounced value that takes the synchronized value only after that value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- The per-bit counter clears whenever the synchronized value matches the debounced value.
REQ-015 SHALL detect an edge on a debounced bit in the cycle the debounced value changes, qualified by EDGE_TYPE.
REQ-016 SHALL use this register map; reads of unlisted addresses return 0, writes are ignored:
- 0 DATA: debounced value, read-only.
- 2 IRQMASK: read/write, WIDTH bits.
- 3 EDGECAP: read, write-1-to-clear.
REQ-017 SHALL update readdata every cycle from the address of the previous cycle (read latency 1), zero-extended to 32 bits, independent of chipselect.
REQ-018 SHALL apply a write when chipselect=1 and write_n=0, effective on the following edge.
REQ-019 SHALL set an EDGECAP bit on a detected edge; the bit stays set until cleared.
REQ-020 SHALL give a same-cycle edge priority over a write-1-to-clear on the same EDGECAP bit: the bit remains set.
REQ-021 SHALL drive irq registered as OR(EDGECAP & IRQMASK); irq rises one cycle after the EDGECAP bit sets and falls one cycle after the clear or mask takes effect.
REQ-022 SHALL leave writedata bits at or above WIDTH without effect.

Reset
REQ-023 SHALL, while reset=1, set synchronizers, debounced values, counters, IRQMASK, EDGECAP, readdata and irq to 0.
REQ-024 SHALL spend 3 cycles after reset release in a settle phase:
- the debounced value loads the synchronized value directly each cycle;
- no edges are detected.
REQ-025 SHALL abort any in-progress debounce count and discard any pending edge if reset is asserted mid-operation.

Structure
REQ-026 SHALL place register address constants, the EDGE_TYPE encoding and the settle length in the shared package nios_pio_pkg.
REQ-027 SHALL implement the synchronizer, debounce counter and edge detector for one bit in the sub-module nios_pio_debounce, instantiated WIDTH times.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4, EDGE_TYPE=RISING)
REQ-028 SHALL cover reset with in_port=8'hFF: after settle, DATA reads 8'hFF, EDGECAP reads 0 and irq=0.
REQ-029 SHALL cover a 3-cycle glitch on in_port[0] 0->1->0: DATA stays 0 and EDGECAP stays 0.
REQ-030 SHALL cover a held 0->1 on in_port[2] with IRQMASK=8'h04:
- DATA[2]=1 exactly 2+4 cycles after the change;
- EDGECAP=8'h04;
- irq=1 one cycle later.
REQ-031 SHALL cover writing 8'h04 to EDGECAP in the same cycle as a new bit-2 edge: EDGECAP remains 8'h04 and irq stays 1.
REQ-032 SHALL cover an edge on bit 5 with IRQMASK=0: EDGECAP=8'h20 and irq=0; writing IRQMASK=8'h20 raises irq one cycle later.
REQ-033 SHALL cover asserting reset mid-debounce (count=2): all state returns to 0 and no edge is reported after release.
